apb_cmd_sequencer: RTL and testbench
====================================

Name: apb_cmd_sequencer

Overview:
Parametrised APB requester that replaces ad-hoc single-shot edge-triggered APB pokes with a queued command engine. It accepts read/write commands through a valid/ready port into a DEPTH-entry FIFO and issues them in order as APB transfers. It supports back-to-back transfers, a pready timeout and tagged responses. It sits between a debug/control source (VIO, bridge, soft CPU) and an APB completer such as the GTY APB bridge's completer side.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TAG_WIDTH, 4, user tag carried from command to response
DEPTH, 4, command FIFO entries; power of 2, >= 2
TIMEOUT_CYCLES, 255, max ACCESS cycles waiting on pready; 0 disables the timeout

Ports:
clk  in  1  sole clock; also drives the APB side (pclk = clk)
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
cmd_tag  in  TAG_WIDTH  user tag
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
rsp_tag  out  TAG_WIDTH  tag of the completed command
apb_psel  out  1
apb_penable  out  1
apb_pwrite  out  1
apb_paddr  out  ADDR_WIDTH
apb_pwdata  out  DATA_WIDTH
apb_prdata  in  DATA_WIDTH
apb_pready  in  1
apb_pslverr  in  1
idle  out  1  FIFO empty and state IDLE
err_count  out  16  saturating count of responses with rsp_err=1

Behaviour:
- Reset: FIFO flushed; state IDLE; psel, penable, rsp_valid, rsp_err and rsp_timeout = 0; paddr, pwdata, pwrite, rsp_rdata and rsp_tag = 0; err_count = 0; cmd_ready = 1; idle = 1.
- Reset during a transfer: psel and penable are low the cycle after rst is sampled. No response is issued for the in-flight or queued commands.
- FIFO push: occurs on cmd_valid && cmd_ready. When full, cmd_ready = 0 and nothing is pushed. A push while full cannot occur.
- An entry pushed in cycle N is visible to the FSM in cycle N+1.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE: if the FIFO is non-empty, pop the head and load paddr, pwdata, pwrite and the tag. Next cycle psel=1, penable=0, state SETUP.
  - Latency: a command pushed into an empty, idle block in cycle N gives psel=1 in cycle N+2.
- SETUP: next cycle penable=1, state ACCESS. Clear the timeout counter.
- ACCESS, pready=1: complete the transfer.
  - Next cycle: rsp_valid=1 with rsp_rdata = prdata (reads) or 0 (writes), rsp_err = pslverr, rsp_timeout = 0, and the latched tag.
  - If the FIFO is non-empty (sampled in the completion cycle), pop and go directly to SETUP: psel stays 1, penable=0, new address. This gives 2 cycles per transfer with zero-wait completers.
  - Otherwise psel=0, penable=0, state IDLE.
- ACCESS, pready=0: increment the timeout counter.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: drop psel and penable, then emit rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - After a timeout, always go to IDLE (at least one cycle with psel=0) before the next transfer.
  - A transfer that completes with pready exactly on cycle TIMEOUT_CYCLES completes normally; pready has priority over timeout.
- apb_paddr, apb_pwdata and apb_pwrite hold stable from SETUP through completion.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged.
- err_count: increments on each rsp_valid with rsp_err=1 and saturates at 0xFFFF.
- idle: combinational (FIFO empty && state == IDLE).

Test Plan:
- Single read: push read addr=0x10, tag=3; completer pready=1 in the first ACCESS with prdata=0xDEADBEEF -> psel rises 2 cycles after the push; rsp_valid 1 cycle after pready; rsp_rdata=0xDEADBEEF, rsp_tag=3, rsp_err=0.
- Back-to-back: push 4 writes (addr 0..3) with a zero-wait completer -> psel stays high throughout; penable toggles every cycle; 4 rsp_valid pulses 2 cycles apart; tags in push order.
- FIFO full: stall pready=0 and push DEPTH+2 commands -> cmd_ready=0 once DEPTH are queued beyond the in-flight one; no command is lost or duplicated after pready resumes.
- Timeout: TIMEOUT_CYCLES=8, pready held 0 -> psel/penable drop after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; err_count=1; next queued command starts from IDLE.
- Slave error: pslverr=1 with pready=1 on a write -> rsp_err=1, rsp_timeout=0; err_count increments. Also force err_count to 0xFFFF, then one more error -> err_count stays 0xFFFF.
- Reset mid-ACCESS with 2 queued -> psel=0 the next cycle; no rsp_valid; idle=1; cmd_ready=1.

Source files
------------

// File: rtl/apb_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// apb_cmd_sequencer_if
//
// Bundles the three signal groups of the APB command sequencer:
//   cmd_*  : command port (source -> sequencer), valid/ready handshake
//   rsp_*  : response port (sequencer -> source), one-cycle pulse
//   apb_*  : APB requester bus (sequencer -> completer and back)
//
// Handshake semantics (cmd port): a command transfers on every rising clk
// edge where cmd_valid && cmd_ready are both 1. The source holds cmd_write,
// cmd_addr, cmd_wdata and cmd_tag stable while cmd_valid is high. cmd_ready
// does not depend on cmd_valid. The response port has no ready: rsp_valid is
// a single-cycle pulse and rsp_* are only meaningful while it is high.
//
// Modports:
//   master : the sequencer side (drives cmd_ready, rsp_*, APB requests)
//   slave  : the environment side (command source, response sink, completer)
// ---------------------------------------------------------------------------
interface apb_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  // command port
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [TAG_WIDTH-1:0]  cmd_tag;

  // response port
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [TAG_WIDTH-1:0]  rsp_tag;

  // APB requester
  logic                  apb_psel;
  logic                  apb_penable;
  logic                  apb_pwrite;
  logic [ADDR_WIDTH-1:0] apb_paddr;
  logic [DATA_WIDTH-1:0] apb_pwdata;
  logic [DATA_WIDTH-1:0] apb_prdata;
  logic                  apb_pready;
  logic                  apb_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_tag,
    output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    input  apb_prdata, apb_pready, apb_pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_tag,
    input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// apb_cmd_sequencer
//
// Queued APB requester. Read/write commands are accepted through a
// valid/ready port into a DEPTH-entry FIFO and issued in order as APB
// transfers on the same clock (pclk = clk). Each finished transfer produces
// a one-cycle tagged response. A stalled completer is abandoned after
// TIMEOUT_CYCLES ACCESS cycles (0 = wait forever).
//
// Ports:
//   clk        : sole clock, also the APB clock
//   rst        : synchronous, active-high reset (flushes FIFO, no responses
//                are issued for flushed or in-flight commands)
//   bus        : apb_cmd_sequencer_if.master (cmd_*, rsp_*, apb_*)
//   idle       : FIFO empty and FSM in IDLE (combinational)
//   err_count  : saturating count of responses with rsp_err = 1
//   dbg_state  : current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
//
// Timing summary:
//   push in cycle N -> FSM sees it in N+1 -> psel = 1 in N+2
//   zero-wait completer with a non-empty queue -> one transfer per 2 cycles
//   rsp_valid follows the completing (or timing-out) cycle by one clock
// ---------------------------------------------------------------------------
module apb_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 4,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  apb_cmd_sequencer_if.master bus,
  output logic        idle,
  output logic [15:0] err_count,
  output logic [1:0]  dbg_state
);

  // -------------------------------------------------------------------------
  // Local parameters
  // -------------------------------------------------------------------------
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;

  // The timer counts completed wait cycles inside ACCESS; it only has to
  // reach TIMEOUT_CYCLES-1, the cycle after that is the abort cycle.
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Command FIFO
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy counter.
  // -------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [ENTRY_W-1:0]    head;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [TAG_WIDTH-1:0]  head_tag;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push       = bus.cmd_valid && !fifo_full;

  assign head       = mem[rd_ptr[PTR_W-1:0]];
  assign head_write = head[ENTRY_W-1];
  assign head_addr  = head[DATA_WIDTH + TAG_WIDTH +: ADDR_WIDTH];
  assign head_wdata = head[TAG_WIDTH +: DATA_WIDTH];
  assign head_tag   = head[0 +: TAG_WIDTH];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM registers
  // -------------------------------------------------------------------------
  state_t                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [TW-1:0]         timer_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic [15:0]           err_count_q;
  logic [15:0]           err_count_inc;

  // A pop happens when the FSM can start a new SETUP next cycle: from IDLE,
  // or from an ACCESS that completes this cycle. A timeout never pops, so the
  // bus always spends at least one cycle deselected after an abort.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == ST_IDLE) begin
        pop = 1'b1;
      end else if (state_q == ST_ACCESS && bus.apb_pready) begin
        pop = 1'b1;
      end
    end
  end

  assign err_count_inc = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      tag_q         <= '0;
      timer_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_tag_q     <= '0;
      err_count_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= head_write;
            paddr_q   <= head_addr;
            pwdata_q  <= head_wdata;
            tag_q     <= head_tag;
            state_q   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable_q <= 1'b1;
          timer_q   <= '0;
          state_q   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // pready is checked first so a completion on the last allowed
          // cycle wins over the timeout.
          if (bus.apb_pready) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.apb_prdata;
            rsp_err_q     <= bus.apb_pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_tag_q     <= tag_q;
            if (bus.apb_pslverr) err_count_q <= err_count_inc;
            penable_q <= 1'b0;
            if (pop) begin
              // Back-to-back: psel stays high, straight into the next SETUP.
              pwrite_q <= head_write;
              paddr_q  <= head_addr;
              pwdata_q <= head_wdata;
              tag_q    <= head_tag;
              state_q  <= ST_SETUP;
            end else begin
              psel_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (TIMEOUT_EN && timer_q == TO_LAST) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_tag_q     <= tag_q;
            err_count_q   <= err_count_inc;
            state_q       <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.cmd_ready   = !fifo_full;
  assign bus.apb_psel    = psel_q;
  assign bus.apb_penable = penable_q;
  assign bus.apb_pwrite  = pwrite_q;
  assign bus.apb_paddr   = paddr_q;
  assign bus.apb_pwdata  = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_tag     = rsp_tag_q;

  assign idle      = fifo_empty && (state_q == ST_IDLE);
  assign err_count = err_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_sequencer
//
// The behavioural completer derives its behaviour from the address:
//   paddr[11:8] : wait states before pready (>= 8 exceeds TIMEOUT_CYCLES = 8)
//   paddr[12]   : pslverr returned with pready
//   read data   : rd_model(paddr)
// so every expected response is known when the command is pushed.
// ---------------------------------------------------------------------------
module tb_apb_cmd_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TGW = 4;
  localparam int TO = 8;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  apb_cmd_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TGW)) bus ();
  logic        idle;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;

  apb_cmd_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TGW),
    .DEPTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .idle(idle),
    .err_count(err_count),
    .dbg_state(dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [TGW+DW+1:0] exp_q[$];   // {tag, rdata, err, timeout}
  logic [64:0]       apb_q[$];   // {write, addr, wdata}
  int                rsp_cyc_q[$];
  int                rsp_seen = 0;
  logic [15:0]       err_exp = 16'h0;
  int                total = 0;
  int                bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [TGW+DW+1:0] exp_rsp(input logic w, input logic [31:0] a,
                                               input logic [3:0] t);
    logic        to;
    logic        er;
    logic [31:0] rd;
    to = (a[11:8] >= 4'd8);
    er = to | a[12];
    rd = (w || to) ? 32'h0 : rd_model(a);
    return {t, rd, er, to};
  endfunction

  // -------------------------------------------------------------------------
  // Completer model + response monitor (completer part runs first so the
  // monitor sees this cycle's last_acc)
  // -------------------------------------------------------------------------
  int          acc_cnt = 0;
  int          last_acc = 0;
  logic [64:0] apb_e;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;
  logic        seen_write;
  logic [TGW+DW+1:0] rsp_e;
  int          pending;

  initial begin
    bus.apb_pready  = 1'b0;
    bus.apb_pslverr = 1'b0;
    bus.apb_prdata  = '0;
  end

  always @(negedge clk) begin
    if (bus.apb_psel && bus.apb_penable) begin
      if (acc_cnt == 0) begin
        seen_addr  = bus.apb_paddr;
        seen_wdata = bus.apb_pwdata;
        seen_write = bus.apb_pwrite;
        pending = apb_q.size();
        check("apb_pending", 64'(pending != 0), 1);
        if (pending != 0) begin
          apb_e = apb_q.pop_front();
          check("apb_pwrite", bus.apb_pwrite, apb_e[64]);
          check("apb_paddr", bus.apb_paddr, apb_e[63:32]);
          if (apb_e[64]) check("apb_pwdata", bus.apb_pwdata, apb_e[31:0]);
        end
      end else begin
        check("apb_hold", {bus.apb_pwrite, bus.apb_paddr, bus.apb_pwdata},
              {seen_write, seen_addr, seen_wdata});
      end
      bus.apb_pready  = (acc_cnt >= int'(bus.apb_paddr[11:8]));
      bus.apb_pslverr = bus.apb_paddr[12];
      bus.apb_prdata  = rd_model(bus.apb_paddr);
      acc_cnt++;
    end else begin
      if (acc_cnt != 0) last_acc = acc_cnt;
      acc_cnt = 0;
      bus.apb_pready  = 1'b0;
      bus.apb_pslverr = 1'b0;
      bus.apb_prdata  = '0;
    end

    if (bus.rsp_valid) begin
      rsp_seen++;
      rsp_cyc_q.push_back(cyc);
      pending = exp_q.size();
      check("rsp_pending", 64'(pending != 0), 1);
      if (pending != 0) begin
        rsp_e = exp_q.pop_front();
        check("rsp_tag", bus.rsp_tag, rsp_e[TGW+DW+1:DW+2]);
        check("rsp_rdata", bus.rsp_rdata, rsp_e[DW+1:2]);
        check("rsp_err", bus.rsp_err, rsp_e[1]);
        check("rsp_timeout", bus.rsp_timeout, rsp_e[0]);
        if (rsp_e[1] && err_exp != 16'hFFFF) err_exp = err_exp + 16'd1;
        if (rsp_e[0]) begin
          check("to_psel_drop", bus.apb_psel, 0);
          check("to_acc_cycles", last_acc, TO);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] t);
    int g = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_tag   = t;
    while (!bus.cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("push_ready", bus.cmd_ready, 1);
    if (bus.cmd_ready) begin
      @(posedge clk);
      exp_q.push_back(exp_rsp(w, a, t));
      apb_q.push_back({w, a, d});
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int p0;
  int g;
  int psel_bad;
  int pen_bad;
  int base;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_tag   = '0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel", bus.apb_psel, 0);
    check("rst_penable", bus.apb_penable, 0);
    check("rst_pwrite", bus.apb_pwrite, 0);
    check("rst_paddr", bus.apb_paddr, 0);
    check("rst_pwdata", bus.apb_pwdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_tag", bus.rsp_tag, 0);
    check("rst_rsp_flags", {bus.rsp_err, bus.rsp_timeout}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // single read: psel one edge after the push edge, response two later
    rsp_cyc_q.delete();
    push_cmd(1'b0, 32'h10, 32'h0, 4'd3);
    p0 = cyc;
    g = 0;
    @(negedge clk);
    while (!bus.apb_psel && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("rd_psel_seen", bus.apb_psel, 1);
    check("rd_psel_latency", cyc - p0, 1);
    drain("rd_drain");
    check("rd_rsp_count", rsp_cyc_q.size(), 1);
    if (rsp_cyc_q.size() > 0) check("rd_rsp_latency", rsp_cyc_q[0] - p0, 3);

    // back-to-back writes with a zero-wait completer
    rsp_cyc_q.delete();
    psel_bad = 0;
    pen_bad = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'(i), 32'hA000_0000 + 32'(i), 4'(8 + i));
      end
      begin
        g = 0;
        @(negedge clk);
        while (!bus.apb_psel && g < 10) begin
          @(negedge clk);
          g++;
        end
        for (int k = 0; k < 8; k++) begin
          if (k != 0) @(negedge clk);
          if (bus.apb_psel !== 1'b1) psel_bad++;
          if (bus.apb_penable !== 1'((k % 2) != 0)) pen_bad++;
        end
        @(negedge clk);
        check("b2b_psel_after", bus.apb_psel, 0);
      end
    join
    check("b2b_psel_high", psel_bad, 0);
    check("b2b_penable_toggle", pen_bad, 0);
    drain("b2b_drain");
    check("b2b_rsp_count", rsp_cyc_q.size(), 4);
    for (int i = 1; i < rsp_cyc_q.size(); i++)
      check("b2b_rsp_spacing", rsp_cyc_q[i] - rsp_cyc_q[i-1], 2);

    // FIFO full: 6 wait states keep the first transfer busy
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'h600 + 32'(i*4), 32'h0, 4'(i));
    @(negedge clk);
    check("full_ready_before", bus.cmd_ready, 1);
    push_cmd(1'b1, 32'h610, 32'h1234_5678, 4'd4);
    @(negedge clk);
    check("full_ready_low", bus.cmd_ready, 0);
    push_cmd(1'b0, 32'h614, 32'h0, 4'd5);
    drain("full_drain");

    // timeout followed by a queued command, then the boundary pair
    push_cmd(1'b0, 32'hF00, 32'h0, 4'd5);
    push_cmd(1'b0, 32'h20, 32'h0, 4'd6);
    drain("to_drain");
    check("to_err_count", err_count, err_exp);
    push_cmd(1'b1, 32'h700, 32'h7777_0000, 4'd7);
    push_cmd(1'b0, 32'h804, 32'h0, 4'd8);
    drain("to_edge_drain");
    check("to_edge_err_count", err_count, err_exp);

    // slave error
    push_cmd(1'b1, 32'h1000, 32'hE000_0001, 4'd9);
    push_cmd(1'b0, 32'h1104, 32'h0, 4'd10);
    drain("slverr_drain");
    check("slverr_err_count", err_count, err_exp);

    // err_count saturation
    @(negedge clk);
    force dut.err_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_count_q;
    err_exp = 16'hFFFF;
    @(negedge clk);
    check("sat_preload", err_count, 16'hFFFF);
    push_cmd(1'b1, 32'h1008, 32'h5, 4'd11);
    drain("sat_drain");
    check("sat_err_count", err_count, err_exp);

    // random mix
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  ws;
      logic [31:0] a;
      ws = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ws = 4'($urandom_range(7, 8));
      a = {19'h0, 1'($urandom_range(0, 3) == 0), ws, 8'($urandom_range(0, 255))};
      push_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand_drain");
    check("rand_err_count", err_count, err_exp);

    // reset in the middle of ACCESS with two commands queued
    push_cmd(1'b0, 32'hF00, 32'h0, 4'd1);
    push_cmd(1'b1, 32'h30, 32'h3, 4'd2);
    push_cmd(1'b0, 32'h34, 32'h0, 4'd4);
    g = 0;
    while (!(bus.apb_psel && bus.apb_penable) && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("mid_access_reached", bus.apb_penable, 1);
    base = rsp_seen;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    apb_q.delete();
    err_exp = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_psel", bus.apb_psel, 0);
    check("mrst_penable", bus.apb_penable, 0);
    check("mrst_idle", idle, 1);
    check("mrst_cmd_ready", bus.cmd_ready, 1);
    check("mrst_err_count", err_count, 0);
    repeat (20) @(negedge clk);
    check("mrst_no_rsp", rsp_seen - base, 0);
    check("mrst_psel_quiet", bus.apb_psel, 0);

    // still usable after reset
    push_cmd(1'b0, 32'h44, 32'h0, 4'd12);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
